// File: rtl/exec_stage.sv
// exec_stage: execute unit with single-cycle ALU ops and an optional
// iterative shift-add multiplier (enabled by defining EXEC_MUL_EN).
// Ports: CLK, Reset (sync, active-high), start, ALUOp[2:0],
//   ReadA/ReadB[W-1:0] in; writeValue[W-1:0], ovValue, Zero, Busy, Done out.
module exec_stage #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         start,
    input  logic [2:0]   ALUOp,
    input  logic [W-1:0] ReadA,
    input  logic [W-1:0] ReadB,
    output logic [W-1:0] writeValue,
    output logic         ovValue,
    output logic         Zero,
    output logic         Busy,
    output logic         Done
);

`ifdef EXEC_MUL_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DONE = 2'd2
    } state_t;
`endif

    state_t state_q, state_d;

    logic [W-1:0] wv_q, wv_d;
    logic         ov_q, ov_d;
    logic         zero_q, zero_d;

    // Single-cycle ALU, evaluated directly on the live operands
    logic [W-1:0] alu_res;
    logic         alu_ov;
    logic [W:0]   sum;
    logic [W:0]   diff;
    logic [W+7:0] shl_ext;
    logic [W+7:0] shr_ext;
    logic         accept;

    // 8 guard bits catch everything a 0..7 shift can push out
    assign sum     = {1'b0, ReadA} + {1'b0, ReadB};
    assign diff    = {1'b0, ReadA} - {1'b0, ReadB};
    assign shl_ext = {8'b0, ReadA} << ReadB[2:0];
    assign shr_ext = {ReadA, 8'b0} >> ReadB[2:0];

    always_comb begin
        alu_res = '0;
        alu_ov  = 1'b0;
        case (ALUOp)
            3'b000: begin
                alu_res = sum[W-1:0];
                alu_ov  = sum[W];
            end
            3'b001: begin
                alu_res = diff[W-1:0];
                alu_ov  = diff[W];
            end
            3'b010: alu_res = ReadA & ReadB;
            3'b011: alu_res = ReadA | ReadB;
            3'b100: alu_res = ReadA ^ ReadB;
            3'b101: begin
                alu_res = shl_ext[W-1:0];
                alu_ov  = |shl_ext[W+7:W];
            end
            3'b110: begin
                alu_res = shr_ext[W+7:8];
                alu_ov  = |shr_ext[7:0];
            end
            default: begin
                alu_res = '0;
                alu_ov  = 1'b0;
            end
        endcase
    end

`ifdef EXEC_MUL_EN
    localparam int CW = $clog2(W) + 1;

    logic [2*W-1:0] mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [2*W-1:0] prod_q, prod_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    assign accept = start && (state_q != MUL);
    assign Busy   = (state_q == MUL);
`else
    assign accept = start;
    assign Busy   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        wv_d    = wv_q;
        ov_d    = ov_q;
        zero_d  = zero_q;
`ifdef EXEC_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
`endif
        if (accept) begin
            if (ALUOp == 3'b111) begin
`ifdef EXEC_MUL_EN
                state_d  = MUL;
                mcand_d  = {{W{1'b0}}, ReadA};
                mplier_d = ReadB;
                prod_d   = '0;
                cnt_d    = '0;
`else
                state_d = DONE;
                wv_d    = '0;
                ov_d    = 1'b0;
                zero_d  = 1'b1;
`endif
            end else begin
                state_d = DONE;
                wv_d    = alu_res;
                ov_d    = alu_ov;
                zero_d  = (alu_res == '0);
            end
`ifdef EXEC_MUL_EN
        end else if (state_q == MUL) begin
            // One multiplier bit per cycle, LSB first
            prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(W - 1)) begin
                state_d = DONE;
                wv_d    = prod_d[W-1:0];
                ov_d    = |prod_d[2*W-1:W];
                zero_d  = (prod_d[W-1:0] == '0);
            end
`endif
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= IDLE;
            wv_q    <= '0;
            ov_q    <= 1'b0;
            zero_q  <= 1'b1;
`ifdef EXEC_MUL_EN
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            wv_q    <= wv_d;
            ov_q    <= ov_d;
            zero_q  <= zero_d;
`ifdef EXEC_MUL_EN
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign writeValue = wv_q;
    assign ovValue    = ov_q;
    assign Zero       = zero_q;
    assign Done       = (state_q == DONE);

endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: vector table plus hand sequences for exec_stage (W=8);
// expected results are queued at issue and popped when Done is seen.
module tb_exec_stage;

    logic       CLK = 1'b0;
    logic       Reset;
    logic       start;
    logic [2:0] ALUOp;
    logic [7:0] ReadA;
    logic [7:0] ReadB;
    logic [7:0] writeValue;
    logic       ovValue;
    logic       Zero;
    logic       Busy;
    logic       Done;

    exec_stage #(.W(8)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .start      (start),
        .ALUOp      (ALUOp),
        .ReadA      (ReadA),
        .ReadB      (ReadB),
        .writeValue (writeValue),
        .ovValue    (ovValue),
        .Zero       (Zero),
        .Busy       (Busy),
        .Done       (Done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] wv;
        logic       ov;
    } vec_t;

    typedef struct {
        logic [7:0] wv;
        logic       ov;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[14];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the sampling edge
    task automatic issue(input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b);
        start = 1'b1;
        ALUOp = op;
        ReadA = a;
        ReadB = b;
        @(posedge CLK);
        #1;
        start = 1'b0;
        ReadA = 8'($urandom);
        ReadB = 8'($urandom);
        @(negedge CLK);
    endtask

    task automatic check_done(input string name);
        exp_t e;
        chk({name, "_done"}, {31'b0, Done}, 32'd1);
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s_sb: got empty queue expected entry", name);
        end else begin
            e = sb.pop_front();
            chk({name, "_wv"}, {24'b0, writeValue}, {24'b0, e.wv});
            chk({name, "_ov"}, {31'b0, ovValue}, {31'b0, e.ov});
            chk({name, "_zero"}, {31'b0, Zero}, {31'b0, (e.wv == 8'h00)});
        end
    endtask

    task automatic push(input logic [7:0] wv, input logic ov);
        exp_t e;
        e.wv = wv;
        e.ov = ov;
        sb.push_back(e);
    endtask

`ifdef EXEC_MUL_EN
    // Called at a negedge; checks Busy window, ignored start, result
    task automatic mul_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] wv, input logic ov,
                          input logic [7:0] prev);
        push(wv, ov);
        issue(3'b111, a, b);
        for (int k = 1; k <= 8; k++) begin
            chk("mul_busy", {31'b0, Busy}, 32'd1);
            chk("mul_nodone", {31'b0, Done}, 32'd0);
            chk("mul_hold", {24'b0, writeValue}, {24'b0, prev});
            if (k == 3) begin
                start = 1'b1;
                ALUOp = 3'b000;
                ReadA = 8'h01;
                ReadB = 8'h01;
                @(posedge CLK);
                #1;
                start = 1'b0;
            end
            @(negedge CLK);
        end
        chk("mul_busy_end", {31'b0, Busy}, 32'd0);
        check_done("mul");
        @(negedge CLK);
        chk("mul_done_len", {31'b0, Done}, 32'd0);
    endtask
`endif

    initial begin
        vecs[0]  = '{3'b000, 8'hFE, 8'h03, 8'h01, 1'b1};
        vecs[1]  = '{3'b001, 8'h10, 8'h10, 8'h00, 1'b0};
        vecs[2]  = '{3'b001, 8'h01, 8'h02, 8'hFF, 1'b1};
        vecs[3]  = '{3'b101, 8'hC1, 8'h02, 8'h04, 1'b1};
        vecs[4]  = '{3'b110, 8'h81, 8'h01, 8'h40, 1'b1};
        vecs[5]  = '{3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0};
        vecs[6]  = '{3'b011, 8'hF0, 8'h0F, 8'hFF, 1'b0};
        vecs[7]  = '{3'b100, 8'hAA, 8'hAA, 8'h00, 1'b0};
        vecs[8]  = '{3'b101, 8'h81, 8'hF8, 8'h81, 1'b0};
        vecs[9]  = '{3'b110, 8'h81, 8'h08, 8'h81, 1'b0};
        vecs[10] = '{3'b101, 8'h01, 8'h07, 8'h80, 1'b0};
        vecs[11] = '{3'b110, 8'h80, 8'h07, 8'h01, 1'b0};
        vecs[12] = '{3'b000, 8'h7F, 8'h01, 8'h80, 1'b0};
        vecs[13] = '{3'b110, 8'h0F, 8'h03, 8'h01, 1'b1};

        Reset = 1'b1;
        start = 1'b0;
        ALUOp = 3'b000;
        ReadA = 8'h00;
        ReadB = 8'h00;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        Reset = 1'b0;
        chk("rst_wv", {24'b0, writeValue}, 32'd0);
        chk("rst_ov", {31'b0, ovValue}, 32'd0);
        chk("rst_zero", {31'b0, Zero}, 32'd1);
        chk("rst_busy", {31'b0, Busy}, 32'd0);
        chk("rst_done", {31'b0, Done}, 32'd0);

        foreach (vecs[i]) begin
            push(vecs[i].wv, vecs[i].ov);
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            check_done($sformatf("vec%0d", i));
            chk("vec_busy", {31'b0, Busy}, 32'd0);
            @(negedge CLK);
            chk("vec_done_len", {31'b0, Done}, 32'd0);
        end

        // Back-to-back ADD then XOR: Done on two consecutive cycles
        push(8'h30, 1'b0);
        issue(3'b000, 8'h10, 8'h20);
        check_done("b2b_add");
        push(8'h5A, 1'b0);
        issue(3'b100, 8'hF0, 8'hAA);
        check_done("b2b_xor");
        @(negedge CLK);
        chk("b2b_done_len", {31'b0, Done}, 32'd0);

        // Reset wins over simultaneous start
        Reset = 1'b1;
        issue(3'b000, 8'hFE, 8'h03);
        Reset = 1'b0;
        chk("rst_start_done", {31'b0, Done}, 32'd0);
        chk("rst_start_wv", {24'b0, writeValue}, 32'd0);
        chk("rst_start_zero", {31'b0, Zero}, 32'd1);

`ifdef EXEC_MUL_EN
        mul_op(8'h10, 8'h11, 8'h10, 1'b1, 8'h00);
        mul_op(8'h0F, 8'h0F, 8'hE1, 1'b0, 8'h10);
        mul_op(8'hFF, 8'hFF, 8'h01, 1'b1, 8'hE1);
        mul_op(8'h00, 8'h37, 8'h00, 1'b0, 8'h01);

        // Reset at t+4 of a MUL aborts it
        push(8'h2A, 1'b0);
        issue(3'b011, 8'h28, 8'h02);
        check_done("pre_abort");
        issue(3'b111, 8'h03, 8'h05);
        for (int k = 1; k <= 3; k++) @(negedge CLK);
        chk("abort_busy_pre", {31'b0, Busy}, 32'd1);
        Reset = 1'b1;
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        @(negedge CLK);
        chk("abort_wv", {24'b0, writeValue}, 32'd0);
        chk("abort_zero", {31'b0, Zero}, 32'd1);
        chk("abort_busy", {31'b0, Busy}, 32'd0);
        for (int k = 0; k < 12; k++) begin
            chk("abort_nodone", {31'b0, Done}, 32'd0);
            @(negedge CLK);
        end
`else
        // ALUOp 111 completes single-cycle with a zero result
        push(8'h00, 1'b0);
        issue(3'b111, 8'h12, 8'h34);
        check_done("mul_off");
        chk("mul_off_busy", {31'b0, Busy}, 32'd0);
        @(negedge CLK);
        chk("mul_off_done_len", {31'b0, Done}, 32'd0);

        // Reset clears a nonzero result
        push(8'hFF, 1'b0);
        issue(3'b011, 8'hF0, 8'h0F);
        check_done("pre_rst");
        Reset = 1'b1;
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        @(negedge CLK);
        chk("rst2_wv", {24'b0, writeValue}, 32'd0);
        chk("rst2_zero", {31'b0, Zero}, 32'd1);
        chk("rst2_done", {31'b0, Done}, 32'd0);
`endif

        chk("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the operand/result width.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an operation.
REQ-005 The block SHALL have port ALUOp, input, 3 bits: operation select.
REQ-006 The block SHALL have ports ReadA and ReadB, input, W bits each: operands from the register file read ports.
REQ-007 The block SHALL have port writeValue, output, W bits: registered result to the register file write data.
REQ-008 The block SHALL have port ovValue, output, 1 bit: registered overflow/carry to the register file OvToReg path.
REQ-009 The block SHALL have port Zero, output, 1 bit: registered flag, high when writeValue equals 0.
REQ-010 The block SHALL have ports Busy and Done, output, 1 bit each: Busy = multi-cycle op in progress; Done = one-cycle completion pulse.

Function
REQ-011 The FSM SHALL have states IDLE, MUL and DONE, and SHALL accept start only when Busy=0 (states IDLE or DONE); start with Busy=1 SHALL be ignored.
REQ-012 On an accepted start, the block SHALL capture ReadA, ReadB and ALUOp at that edge; later operand changes SHALL have no effect.
REQ-013 Single-cycle ops (ALUOp 000-110) SHALL update writeValue/ovValue/Zero at the accepting edge t, and Done SHALL be 1 for exactly cycle t+1.
REQ-014 000 ADD: result = (A+B) mod 2^W; ov = carry out.
REQ-015 001 SUB: result = (A-B) mod 2^W; ov = 1 iff A<B unsigned.
REQ-016 010 AND, 011 OR, 100 XOR: bitwise result; ov = 0.
REQ-017 101 SHL by B[2:0]: ov = 1 iff any bit shifted out is 1; a shift of 0 gives result A, ov 0.
REQ-018 110 SHR (logical) by B[2:0]: ov = 1 iff any bit shifted out is 1; a shift of 0 gives result A, ov 0.
REQ-019 111 MUL SHALL use iterative shift-add, one multiplier bit per cycle: Busy=1 for cycles t+1..t+W, then results update and Done=1 in cycle t+W+1.
REQ-020 MUL SHALL give result = low W bits of the 2W-bit product; ov = 1 iff the high W bits are nonzero.
REQ-021 writeValue, ovValue and Zero SHALL hold their values until the next completion; during MUL they SHALL keep the previous results.
REQ-022 A start accepted in DONE SHALL begin immediately, allowing back-to-back single-cycle ops to pulse Done on consecutive cycles.

Reset
REQ-023 While Reset=1 at a rising edge: FSM -> IDLE; writeValue=0, ovValue=0, Zero=1, Busy=0, Done=0; internal counter/product cleared.
REQ-024 Reset SHALL win over a simultaneous start, and Reset during MUL SHALL abort with no Done pulse.

Configuration
REQ-025 With macro EXEC_MUL_EN defined, ALUOp 111 SHALL perform MUL per REQ-019/020.
REQ-026 Without EXEC_MUL_EN, the MUL state and datapath SHALL be absent, Busy SHALL be constant 0, and ALUOp 111 SHALL complete single-cycle with result 0, ov 0, Zero 1.

Verification
REQ-027 ADD test: W=8, A=8'hFE, B=8'h03, start -> next cycle writeValue=8'h01, ovValue=1, Zero=0, Done=1 for one cycle.
REQ-028 SUB/Zero test: A=8'h10, B=8'h10 -> writeValue=8'h00, ov=0, Zero=1; then A=8'h01, B=8'h02 -> writeValue=8'hFF, ov=1.
REQ-029 Shift test: SHL with A=8'hC1, B=3'd2 -> writeValue=8'h04, ov=1; SHR with A=8'h81, B=3'd1 -> writeValue=8'h40, ov=1.
REQ-030 MUL test (EXEC_MUL_EN): A=8'h10, B=8'h11 -> Busy=1 for 8 cycles, then writeValue=8'h10, ov=1, Done pulse at cycle t+9; a start at t+3 is ignored.
REQ-031 Reset abort: Reset=1 at t+4 of a MUL -> IDLE, writeValue=0, Zero=1, Busy=0, and no Done pulse.
REQ-032 Back-to-back: ADD then XOR starts on consecutive cycles -> Done=1 on two consecutive cycles, each with the correct result.
